// File: rtl/serv_seq_pkg.sv
// Shared types and helpers for the bit-serial sequencing controller.
// The slice index is always 5 bits wide because one pass covers a 32-bit word.
package serv_seq_pkg;

  localparam int POS_W     = 5;
  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_RFRD,
    ST_INIT,
    ST_WAIT,
    ST_RFWR,
    ST_EXEC
  } state_t;

  function automatic bit legal_w(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

  function automatic int steps_for(input int w);
    return WORD_BITS / w;
  endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// Step counter for one 32-bit pass of W-bit slices.
// It wraps to zero after the last step so the next pass always starts clean.
module serv_seq_cnt
  import serv_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [POS_W-1:0] o_pos,
  output logic             o_first,
  output logic             o_done,
  output logic             o_cnt0to3,
  output logic             o_cnt12to31
);

  localparam int STEPS = steps_for(W);
  localparam int SHIFT = $clog2(W);

  logic [POS_W-1:0] step_q, step_d;
  logic             last_step;

  always_comb begin
    last_step = (step_q == POS_W'(STEPS - 1));
    step_d    = step_q;
    if (i_en) begin
      step_d = last_step ? '0 : step_q + POS_W'(1);
    end
    o_pos       = step_q << SHIFT;
    o_first     = i_en & (step_q == '0);
    o_done      = i_en & last_step;
    o_cnt0to3   = (o_pos < POS_W'(4));
    o_cnt12to31 = (o_pos >= POS_W'(12));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/serv_seq_ctrl.sv
// Sequencing controller for a W-bit-per-cycle serial core: fetch, RF read,
// optional init pass, bus/MDU wait, RF write and execute pass.
module serv_seq_ctrl
  import serv_seq_pkg::*;
#(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1,
  parameter bit ALIGN    = 1'b0,
  parameter bit MDU      = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_ibus_ack,
  input  logic             i_rf_ready,
  input  logic             i_dbus_ack,
  input  logic             i_mdu_ready,
  input  logic             i_two_stage_op,
  input  logic             i_branch_op,
  input  logic             i_cond_branch,
  input  logic             i_bne_or_bge,
  input  logic             i_dbus_en,
  input  logic             i_mdu_op,
  input  logic             i_slt_or_branch,
  input  logic             i_e_op,
  input  logic             i_alu_cmp,
  input  logic             i_ctrl_misalign,
  input  logic             i_mem_misalign,
  input  logic             i_new_irq,
  output logic             o_ibus_cyc,
  output logic             o_dbus_cyc,
  output logic             o_mdu_valid,
  output logic             o_rf_rreq,
  output logic             o_rf_wreq,
  output logic             o_cnt_en,
  output logic [POS_W-1:0] o_cnt_pos,
  output logic             o_cnt_first,
  output logic             o_cnt_done,
  output logic             o_cnt0to3,
  output logic             o_cnt12to31,
  output logic [1:0]       o_mem_bytecnt,
  output logic             o_init,
  output logic             o_ctrl_pc_en,
  output logic             o_ctrl_jump,
  output logic             o_ctrl_trap
);

  if (!legal_w(W)) begin : g_bad_w
    $error("serv_seq_ctrl: W must be 1, 2, 4 or 8");
  end

  state_t           state_q, state_d;
  logic             jump_q, jump_d;
  logic             trap_q, trap_d;
  logic             stage2_q, stage2_d;
  logic             cnt_en;
  logic [POS_W-1:0] pos;
  logic             first, done, c0to3, c12to31;
  logic             take_branch, wait_exit;
  logic             ibus_cyc, dbus_cyc, mdu_valid, rf_rreq, rf_wreq, init, pc_en;

  // Stall only has meaning while a counting pass is in progress.
  assign cnt_en = ((state_q == ST_INIT) || (state_q == ST_EXEC)) && !i_stall;

  serv_seq_cnt #(.W(W)) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (cnt_en),
    .o_pos       (pos),
    .o_first     (first),
    .o_done      (done),
    .o_cnt0to3   (c0to3),
    .o_cnt12to31 (c12to31)
  );

  always_comb begin
    state_d   = state_q;
    jump_d    = jump_q;
    trap_d    = trap_q;
    stage2_d  = stage2_q;
    ibus_cyc  = 1'b0;
    dbus_cyc  = 1'b0;
    mdu_valid = 1'b0;
    rf_rreq   = 1'b0;
    rf_wreq   = 1'b0;
    init      = 1'b0;
    pc_en     = 1'b0;

    take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
    wait_exit   = i_dbus_ack | (MDU & i_mdu_ready) | i_slt_or_branch |
                  (!i_dbus_en & !i_mdu_op);

    case (state_q)
      ST_FETCH: begin
        ibus_cyc = 1'b1;
        if (i_ibus_ack) begin
          rf_rreq = 1'b1;
          trap_d  = 1'b0;
          state_d = ST_RFRD;
        end
      end
      ST_RFRD: begin
        if (i_rf_ready) begin
          state_d = (stage2_q || !i_two_stage_op || i_new_irq) ? ST_EXEC : ST_INIT;
        end
      end
      ST_INIT: begin
        init = 1'b1;
        if (done) begin
          jump_d  = take_branch;
          trap_d  = WITH_CSR & ((take_branch & i_ctrl_misalign & !ALIGN) |
                                (i_dbus_en & i_mem_misalign));
          state_d = ST_WAIT;
        end
      end
      // A pending trap skips the bus access and re-reads the RF for the handler.
      ST_WAIT: begin
        if (trap_q) begin
          rf_rreq  = 1'b1;
          stage2_d = 1'b1;
          state_d  = ST_RFRD;
        end else begin
          dbus_cyc  = i_dbus_en;
          mdu_valid = MDU & i_mdu_op;
          if (wait_exit) begin
            state_d = ST_RFWR;
          end
        end
      end
      ST_RFWR: begin
        rf_wreq  = 1'b1;
        stage2_d = 1'b1;
        state_d  = ST_RFRD;
      end
      ST_EXEC: begin
        pc_en = cnt_en;
        if (done) begin
          stage2_d = 1'b0;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_FETCH;
      jump_q   <= 1'b0;
      trap_q   <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      jump_q   <= jump_d;
      trap_q   <= trap_d;
      stage2_q <= stage2_d;
    end
  end

  // Outputs are forced low for the whole cycle in which reset is asserted.
  always_comb begin
    o_ibus_cyc    = ibus_cyc & !i_rst;
    o_dbus_cyc    = dbus_cyc & !i_rst;
    o_mdu_valid   = mdu_valid & !i_rst;
    o_rf_rreq     = rf_rreq & !i_rst;
    o_rf_wreq     = rf_wreq & !i_rst;
    o_cnt_en      = cnt_en & !i_rst;
    o_cnt_pos     = i_rst ? '0 : pos;
    o_cnt_first   = first & !i_rst;
    o_cnt_done    = done & !i_rst;
    o_cnt0to3     = c0to3 & !i_rst;
    o_cnt12to31   = c12to31 & !i_rst;
    o_mem_bytecnt = i_rst ? 2'b00 : pos[POS_W-1 -: 2];
    o_init        = init & !i_rst;
    o_ctrl_pc_en  = pc_en & !i_rst;
    o_ctrl_jump   = jump_q & !i_rst;
    o_ctrl_trap   = !i_rst & WITH_CSR & (i_e_op | i_new_irq | trap_q);
  end

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Self-checking bench: three controller configurations share one stimulus stream
// and are each compared every cycle against a pass-level reference model.
module tb_serv_seq_ctrl;

  typedef struct packed {
    logic stall, ibus_ack, rf_ready, dbus_ack, mdu_ready, two_stage_op, branch_op,
          cond_branch, bne_or_bge, dbus_en, mdu_op, slt_or_branch, e_op, alu_cmp,
          ctrl_misalign, mem_misalign, new_irq;
  } in_t;

  typedef struct packed {
    logic       ibus_cyc, dbus_cyc, mdu_valid, rf_rreq, rf_wreq, cnt_en;
    logic [4:0] cnt_pos;
    logic       cnt_first, cnt_done, cnt0to3, cnt12to31;
    logic [1:0] mem_bytecnt;
    logic       init, pc_en, jump, trap;
  } out_t;

  typedef enum {PH_FETCH, PH_RFRD, PH_INIT, PH_WAIT, PH_RFWR, PH_EXEC} ph_t;
  typedef struct {ph_t ph; int step; bit jump; bit trapr; bit stage2;} mst_t;
  typedef struct {int w; bit csr; bit align; bit mdu;} mpar_t;
  typedef struct {in_t inp; bit rst; out_t exp;} vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  in_t   in_v = '0;
  wire out_t dout0, dout1, dout2;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  mst_t  ms  [3];
  mpar_t mp  [3];
  out_t  smp [3];
  vec_t  tbl [$];

  always #5 clk = ~clk;

  // dut0: W=4, traps on, MDU on. dut1: W=1, ALIGN=1, MDU off. dut2: W=8, traps off, MDU on.
  serv_seq_ctrl #(.W(4), .WITH_CSR(1'b1), .ALIGN(1'b0), .MDU(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_stall(in_v.stall), .i_ibus_ack(in_v.ibus_ack),
    .i_rf_ready(in_v.rf_ready), .i_dbus_ack(in_v.dbus_ack), .i_mdu_ready(in_v.mdu_ready),
    .i_two_stage_op(in_v.two_stage_op), .i_branch_op(in_v.branch_op),
    .i_cond_branch(in_v.cond_branch), .i_bne_or_bge(in_v.bne_or_bge), .i_dbus_en(in_v.dbus_en),
    .i_mdu_op(in_v.mdu_op), .i_slt_or_branch(in_v.slt_or_branch), .i_e_op(in_v.e_op),
    .i_alu_cmp(in_v.alu_cmp), .i_ctrl_misalign(in_v.ctrl_misalign),
    .i_mem_misalign(in_v.mem_misalign), .i_new_irq(in_v.new_irq),
    .o_ibus_cyc(dout0.ibus_cyc), .o_dbus_cyc(dout0.dbus_cyc), .o_mdu_valid(dout0.mdu_valid),
    .o_rf_rreq(dout0.rf_rreq), .o_rf_wreq(dout0.rf_wreq), .o_cnt_en(dout0.cnt_en),
    .o_cnt_pos(dout0.cnt_pos), .o_cnt_first(dout0.cnt_first), .o_cnt_done(dout0.cnt_done),
    .o_cnt0to3(dout0.cnt0to3), .o_cnt12to31(dout0.cnt12to31), .o_mem_bytecnt(dout0.mem_bytecnt),
    .o_init(dout0.init), .o_ctrl_pc_en(dout0.pc_en), .o_ctrl_jump(dout0.jump),
    .o_ctrl_trap(dout0.trap)
  );

  serv_seq_ctrl #(.W(1), .WITH_CSR(1'b1), .ALIGN(1'b1), .MDU(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stall(in_v.stall), .i_ibus_ack(in_v.ibus_ack),
    .i_rf_ready(in_v.rf_ready), .i_dbus_ack(in_v.dbus_ack), .i_mdu_ready(in_v.mdu_ready),
    .i_two_stage_op(in_v.two_stage_op), .i_branch_op(in_v.branch_op),
    .i_cond_branch(in_v.cond_branch), .i_bne_or_bge(in_v.bne_or_bge), .i_dbus_en(in_v.dbus_en),
    .i_mdu_op(in_v.mdu_op), .i_slt_or_branch(in_v.slt_or_branch), .i_e_op(in_v.e_op),
    .i_alu_cmp(in_v.alu_cmp), .i_ctrl_misalign(in_v.ctrl_misalign),
    .i_mem_misalign(in_v.mem_misalign), .i_new_irq(in_v.new_irq),
    .o_ibus_cyc(dout1.ibus_cyc), .o_dbus_cyc(dout1.dbus_cyc), .o_mdu_valid(dout1.mdu_valid),
    .o_rf_rreq(dout1.rf_rreq), .o_rf_wreq(dout1.rf_wreq), .o_cnt_en(dout1.cnt_en),
    .o_cnt_pos(dout1.cnt_pos), .o_cnt_first(dout1.cnt_first), .o_cnt_done(dout1.cnt_done),
    .o_cnt0to3(dout1.cnt0to3), .o_cnt12to31(dout1.cnt12to31), .o_mem_bytecnt(dout1.mem_bytecnt),
    .o_init(dout1.init), .o_ctrl_pc_en(dout1.pc_en), .o_ctrl_jump(dout1.jump),
    .o_ctrl_trap(dout1.trap)
  );

  serv_seq_ctrl #(.W(8), .WITH_CSR(1'b0), .ALIGN(1'b0), .MDU(1'b1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_stall(in_v.stall), .i_ibus_ack(in_v.ibus_ack),
    .i_rf_ready(in_v.rf_ready), .i_dbus_ack(in_v.dbus_ack), .i_mdu_ready(in_v.mdu_ready),
    .i_two_stage_op(in_v.two_stage_op), .i_branch_op(in_v.branch_op),
    .i_cond_branch(in_v.cond_branch), .i_bne_or_bge(in_v.bne_or_bge), .i_dbus_en(in_v.dbus_en),
    .i_mdu_op(in_v.mdu_op), .i_slt_or_branch(in_v.slt_or_branch), .i_e_op(in_v.e_op),
    .i_alu_cmp(in_v.alu_cmp), .i_ctrl_misalign(in_v.ctrl_misalign),
    .i_mem_misalign(in_v.mem_misalign), .i_new_irq(in_v.new_irq),
    .o_ibus_cyc(dout2.ibus_cyc), .o_dbus_cyc(dout2.dbus_cyc), .o_mdu_valid(dout2.mdu_valid),
    .o_rf_rreq(dout2.rf_rreq), .o_rf_wreq(dout2.rf_wreq), .o_cnt_en(dout2.cnt_en),
    .o_cnt_pos(dout2.cnt_pos), .o_cnt_first(dout2.cnt_first), .o_cnt_done(dout2.cnt_done),
    .o_cnt0to3(dout2.cnt0to3), .o_cnt12to31(dout2.cnt12to31), .o_mem_bytecnt(dout2.mem_bytecnt),
    .o_init(dout2.init), .o_ctrl_pc_en(dout2.pc_en), .o_ctrl_jump(dout2.jump),
    .o_ctrl_trap(dout2.trap)
  );

  // Counter-related outputs for step k of a pass at width w.
  function automatic out_t cnt_exp(int k, int w, bit en);
    out_t o   = '0;
    int   pos = k * w;
    o.cnt_en      = en;
    o.cnt_pos     = 5'(pos);
    o.cnt_first   = en && (k == 0);
    o.cnt_done    = en && (k == 32 / w - 1);
    o.cnt0to3     = (pos < 4);
    o.cnt12to31   = (pos >= 12);
    o.mem_bytecnt = 2'(pos / 8);
    return o;
  endfunction

  function automatic out_t model_out(mst_t s, mpar_t p, in_t i, bit r);
    out_t o;
    bit   counting;
    if (r) return '0;
    counting = (s.ph == PH_INIT) || (s.ph == PH_EXEC);
    o = cnt_exp(s.step, p.w, counting && !i.stall);
    o.jump = s.jump;
    o.trap = p.csr && (i.e_op || i.new_irq || s.trapr);
    case (s.ph)
      PH_FETCH: begin o.ibus_cyc = 1'b1; o.rf_rreq = i.ibus_ack; end
      PH_INIT:  o.init = 1'b1;
      PH_EXEC:  o.pc_en = !i.stall;
      PH_WAIT:  begin
        if (s.trapr) o.rf_rreq = 1'b1;
        else begin o.dbus_cyc = i.dbus_en; o.mdu_valid = p.mdu && i.mdu_op; end
      end
      PH_RFWR:  o.rf_wreq = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

  function automatic mst_t model_next(mst_t s, mpar_t p, in_t i, bit r);
    mst_t n = s;
    bit   last = (s.step == 32 / p.w - 1);
    bit   take;
    if (r) begin
      n.ph = PH_FETCH; n.step = 0; n.jump = 0; n.trapr = 0; n.stage2 = 0;
      return n;
    end
    take = i.branch_op && (!i.cond_branch || (i.alu_cmp != i.bne_or_bge));
    case (s.ph)
      PH_FETCH: if (i.ibus_ack) begin n.trapr = 0; n.ph = PH_RFRD; end
      PH_RFRD:  if (i.rf_ready)
                  n.ph = (s.stage2 || !i.two_stage_op || i.new_irq) ? PH_EXEC : PH_INIT;
      PH_INIT:  if (!i.stall) begin
        n.step = last ? 0 : s.step + 1;
        if (last) begin
          n.jump  = take;
          n.trapr = p.csr && ((take && i.ctrl_misalign && !p.align) ||
                              (i.dbus_en && i.mem_misalign));
          n.ph    = PH_WAIT;
        end
      end
      PH_WAIT:  begin
        if (s.trapr) begin n.stage2 = 1; n.ph = PH_RFRD; end
        else if (i.dbus_ack || (p.mdu && i.mdu_ready) || i.slt_or_branch ||
                 (!i.dbus_en && !i.mdu_op)) n.ph = PH_RFWR;
      end
      PH_RFWR:  begin n.stage2 = 1; n.ph = PH_RFRD; end
      PH_EXEC:  if (!i.stall) begin
        n.step = last ? 0 : s.step + 1;
        if (last) begin n.stage2 = 0; n.ph = PH_FETCH; end
      end
      default:  ;
    endcase
    return n;
  endfunction

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Drive one cycle, compare all three DUTs to the model, then advance on the edge.
  task automatic applyStimulus(input in_t v, input bit r);
    mst_t nxt [3];
    @(negedge clk);
    in_v = v;
    rst  = r;
    #1;
    smp[0] = dout0; smp[1] = dout1; smp[2] = dout2;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("model_dut%0d", i), 32'(smp[i]), 32'(model_out(ms[i], mp[i], v, r)));
      nxt[i] = model_next(ms[i], mp[i], v, r);
    end
    @(posedge clk);
    ms = nxt;
    cyc++;
  endtask

  task automatic resetSeq();
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
  endtask

  function automatic void addRow(in_t v, bit r, out_t e);
    vec_t row;
    row.inp = v; row.rst = r; row.exp = e;
    tbl.push_back(row);
  endfunction

  initial begin
    in_t         v, beq;
    out_t        e;
    int          cnt_a, cnt_b;
    logic [31:0] rnd;

    mp[0] = '{w: 4, csr: 1'b1, align: 1'b0, mdu: 1'b1};
    mp[1] = '{w: 1, csr: 1'b1, align: 1'b1, mdu: 1'b0};
    mp[2] = '{w: 8, csr: 1'b0, align: 1'b0, mdu: 1'b1};
    for (int i = 0; i < 3; i++) ms[i] = '{ph: PH_FETCH, step: 0, jump: 0, trapr: 0, stage2: 0};

    // Taken BEQ on the W=4 instance, expected outputs written per cycle.
    beq = '0;
    beq.two_stage_op = 1; beq.branch_op = 1; beq.cond_branch = 1;
    beq.alu_cmp = 1; beq.slt_or_branch = 1;
    addRow('0, 1'b1, '0);
    e = cnt_exp(0, 4, 0); e.ibus_cyc = 1; addRow('0, 1'b0, e);
    v = beq; v.ibus_ack = 1; e.rf_rreq = 1; addRow(v, 1'b0, e);
    e = cnt_exp(0, 4, 0); addRow(beq, 1'b0, e);
    v = beq; v.rf_ready = 1; addRow(v, 1'b0, e);
    for (int k = 0; k < 8; k++) begin e = cnt_exp(k, 4, 1); e.init = 1; addRow(beq, 1'b0, e); end
    e = cnt_exp(0, 4, 0); e.jump = 1; addRow(beq, 1'b0, e);
    e.rf_wreq = 1; addRow(beq, 1'b0, e);
    e.rf_wreq = 0; v = beq; v.rf_ready = 1; addRow(v, 1'b0, e);
    for (int k = 0; k < 8; k++) begin
      e = cnt_exp(k, 4, 1); e.pc_en = 1; e.jump = 1; addRow(beq, 1'b0, e);
    end
    e = cnt_exp(0, 4, 0); e.ibus_cyc = 1; e.jump = 1; addRow(beq, 1'b0, e);

    $display("[TB] table: %0d vectors", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].inp, tbl[i].rst);
      checkOutput($sformatf("vec%0d", i), 32'(smp[0]), 32'(tbl[i].exp));
    end

    // Single-stage op on W=1 with a 5-cycle stall at pos 10.
    resetSeq();
    v = '0; v.ibus_ack = 1; applyStimulus(v, 1'b0);
    v = '0; v.rf_ready = 1; applyStimulus(v, 1'b0);
    v = '0;
    for (int c = 0; c < 37; c++) begin
      v.stall = (c >= 10 && c < 15);
      applyStimulus(v, 1'b0);
      checkOutput("stall_pos", 32'(smp[1].cnt_pos), (c < 10) ? c : ((c < 15) ? 10 : c - 5));
      checkOutput("stall_en", 32'(smp[1].cnt_en), 32'(!(c >= 10 && c < 15)));
      checkOutput("stall_done", 32'(smp[1].cnt_done), 32'(c == 36));
    end
    v.stall = 0;
    applyStimulus(v, 1'b0);
    checkOutput("stall_refetch", 32'(smp[1].ibus_cyc), 1);

    // Reset arriving mid execute pass on W=1.
    resetSeq();
    v = '0; v.ibus_ack = 1; applyStimulus(v, 1'b0);
    v = '0; v.rf_ready = 1; applyStimulus(v, 1'b0);
    v = '0;
    for (int c = 0; c < 17; c++) applyStimulus(v, 1'b0);
    checkOutput("rst_prepos", 32'(smp[1].cnt_pos), 16);
    applyStimulus(v, 1'b1);
    checkOutput("rst_outputs", 32'(smp[1]), 0);
    applyStimulus(v, 1'b0);
    checkOutput("rst_refetch", 32'(smp[1].ibus_cyc), 1);
    checkOutput("rst_cnt_en", 32'(smp[1].cnt_en), 0);

    // Load on W=8: bus ack in the third wait cycle.
    resetSeq();
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 17; c++) begin
      v = '0; v.two_stage_op = 1; v.dbus_en = 1;
      v.ibus_ack = (c == 0); v.rf_ready = (c != 0); v.dbus_ack = (c == 8);
      applyStimulus(v, 1'b0);
      if (smp[2].dbus_cyc) cnt_a++;
      if (smp[2].rf_wreq) cnt_b++;
      if (c == 9) checkOutput("lw_wreq", 32'(smp[2].rf_wreq), 1);
      if (c >= 11 && c <= 14) begin
        checkOutput("lw_bytecnt", 32'(smp[2].mem_bytecnt), c - 11);
        checkOutput("lw_pc_en", 32'(smp[2].pc_en), 1);
      end
    end
    checkOutput("lw_dbus_cycles", cnt_a, 3);
    checkOutput("lw_wreq_pulses", cnt_b, 1);

    // Misaligned taken jump: traps on W=4 (ALIGN=0), not on W=1 (ALIGN=1) or W=8 (no CSR).
    resetSeq();
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 41; c++) begin
      v = '0; v.two_stage_op = 1; v.branch_op = 1; v.ctrl_misalign = 1; v.dbus_en = 1;
      v.ibus_ack = (c == 0); v.rf_ready = (c != 0);
      applyStimulus(v, 1'b0);
      if (smp[1].trap || smp[2].trap) cnt_a++;
      if (smp[1].dbus_cyc) cnt_b++;
      if (c == 9) checkOutput("jal_trap_pre", 32'(smp[0].trap), 0);
      if (c == 10) begin
        checkOutput("jal_wait_rreq", 32'(smp[0].rf_rreq), 1);
        checkOutput("jal_wait_nobus", 32'(smp[0].dbus_cyc), 0);
      end
      if (c >= 10 && c <= 19) checkOutput("jal_trap", 32'(smp[0].trap), 1);
      if (c >= 12 && c <= 19) checkOutput("jal_exec_pc_en", 32'(smp[0].pc_en), 1);
    end
    checkOutput("jal_align_notrap", cnt_a, 0);
    checkOutput("jal_align_bus", 32'(cnt_b != 0), 1);

    // Random traffic against the model.
    resetSeq();
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      v = rnd[16:0];
      v.stall   = ($urandom_range(0, 7) == 0);
      v.e_op    = ($urandom_range(0, 15) == 0);
      v.new_irq = ($urandom_range(0, 15) == 0);
      applyStimulus(v, ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
